fp_mul_seq_ctrl: RTL and testbench

//  Sequential FP32 multiply controller. Accepts one operand pair per transaction (valid/ready) and

---
 rtl/fp_mul_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fp_mul_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fp_mul_seq_ctrl
// Sequential FP32 multiplier controller. One operand pair is accepted per
// transaction, the 24x24 mantissa product is built with radix-4 Booth digits
// on a single shared 50-bit signed accumulator, and the result is then
// normalised and rounded. NaN, infinity, zero and subnormal operands bypass
// the datapath. Subnormal inputs are flushed to zero. Subnormal outputs are
// flushed to zero with udrf set.
//
// Build option:
//   FP_MUL_DIGIT2_EN  when defined, two Booth digits are retired per CALC cycle
//                     (7 CALC cycles instead of 13). Results are identical.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   controller idle, operand pair accepted when in_valid=1
//   fp_X       in  32   multiplier operand (Booth-recoded)
//   fp_Y       in  32   multiplicand operand
//   r_mode     in   3   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others RNE
//   out_valid  out  1   result valid (held until out_ready)
//   out_ready  in   1   consumer accepts result
//   fp_Z       out 32   product
//   ovrf       out  1   overflow flag, qualified by out_valid
//   udrf       out  1   underflow flag, qualified by out_valid
//   busy       out  1   controller not idle
// -----------------------------------------------------------------------------
module fp_mul_seq_ctrl #(
    parameter int EXP_BIAS   = 127,
    parameter int NUM_DIGITS = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RND  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [23:0]        r_mx;
    logic [23:0]        r_my;
    logic [7:0]         r_ex;
    logic [7:0]         r_ey;
    logic               r_sign;
    logic [2:0]         r_rmode;
    logic [3:0]         r_cnt;
    logic signed [49:0] r_acc;
    logic [31:0]        r_z;
    logic               r_ovrf;
    logic               r_udrf;

    // Booth radix-4 partial product for digit idx, already shifted by 2*idx.
    // mext holds the multiplier with an implicit m[-1]=0 at bit 0 and zero
    // padding above, so digit idx reads mext[2*idx +: 3].
    function automatic logic signed [49:0] booth_pp(input logic [28:0] mext,
                                                    input logic [23:0] mcand,
                                                    input logic [3:0]  idx);
        logic signed [49:0] v_m;
        logic signed [49:0] v_pp;
        logic [2:0]         v_bits;
        v_bits = mext[{idx, 1'b0} +: 3];
        v_m    = $signed({26'd0, mcand});
        case (v_bits)
            3'b001, 3'b010: v_pp = v_m;
            3'b011:         v_pp = v_m <<< 1;
            3'b100:         v_pp = -(v_m <<< 1);
            3'b101, 3'b110: v_pp = -v_m;
            default:        v_pp = '0;
        endcase
        return v_pp <<< {idx, 1'b0};
    endfunction

    // Round-up decision from guard/sticky and the result sign.
    function automatic logic round_inc(input logic [2:0] mode, input logic s,
                                       input logic lsb, input logic g, input logic st);
        case (mode)
            3'b001:  return 1'b0;
            3'b010:  return s & (g | st);
            3'b011:  return ~s & (g | st);
            3'b100:  return g;
            default: return g & (st | lsb);
        endcase
    endfunction

    // Saturated result on exponent overflow: directed modes pick between
    // infinity and the largest finite magnitude depending on sign.
    function automatic logic [31:0] ovf_result(input logic [2:0] mode, input logic s);
        case (mode)
            3'b001:  return {s, 31'h7F7F_FFFF};
            3'b010:  return s ? 32'hFF80_0000 : 32'h7F7F_FFFF;
            3'b011:  return s ? 32'hFF7F_FFFF : 32'h7F80_0000;
            default: return {s, 8'hFF, 23'd0};
        endcase
    endfunction

    // ---------------- operand classification (IDLE accept) ----------------
    logic        w_accept;
    logic        w_sign_in;
    logic        w_x_nan, w_y_nan, w_x_inf, w_y_inf, w_x_zs, w_y_zs;
    logic        w_special;
    logic [31:0] w_spec_z;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_sign_in = fp_X[31] ^ fp_Y[31];
    assign w_x_nan   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] != 23'd0);
    assign w_y_nan   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] != 23'd0);
    assign w_x_inf   = (fp_X[30:23] == 8'hFF) && (fp_X[22:0] == 23'd0);
    assign w_y_inf   = (fp_Y[30:23] == 8'hFF) && (fp_Y[22:0] == 23'd0);
    assign w_x_zs    = (fp_X[30:23] == 8'h00);
    assign w_y_zs    = (fp_Y[30:23] == 8'h00);
    assign w_special = w_x_nan | w_y_nan | w_x_inf | w_y_inf | w_x_zs | w_y_zs;

    always_comb begin
        w_spec_z = {w_sign_in, 31'd0};
        if (w_x_nan || w_y_nan || (w_x_inf && w_y_zs) || (w_y_inf && w_x_zs)) begin
            w_spec_z = 32'h7FC0_0000;
        end else if (w_x_inf || w_y_inf) begin
            w_spec_z = {w_sign_in, 8'hFF, 23'd0};
        end
    end

    // ---------------- Booth digit selection ----------------
    logic [28:0]        w_mext;
    logic signed [49:0] w_pp;
    logic               w_last;

    assign w_mext = {4'd0, r_mx, 1'b0};

`ifdef FP_MUL_DIGIT2_EN
    localparam logic [3:0] LAST_CNT = 4'((NUM_DIGITS + 1) / 2 - 1);
    logic [3:0] w_idx_a;
    logic [3:0] w_idx_b;
    assign w_idx_a = {r_cnt[2:0], 1'b0};
    assign w_idx_b = {r_cnt[2:0], 1'b1};
    assign w_pp    = booth_pp(w_mext, r_my, w_idx_a) + booth_pp(w_mext, r_my, w_idx_b);
`else
    localparam logic [3:0] LAST_CNT = 4'(NUM_DIGITS - 1);
    assign w_pp = booth_pp(w_mext, r_my, r_cnt);
`endif

    assign w_last = (r_cnt == LAST_CNT);

    // ---------------- normalise / round / range check ----------------
    logic [47:0]        w_prod;
    logic signed [9:0]  w_e0, w_e1, w_e2;
    logic [23:0]        w_mant;
    logic [23:0]        w_mant_f;
    logic [24:0]        w_mant_r;
    logic               w_g, w_st, w_inc;
    logic [31:0]        w_rnd_z;
    logic               w_rnd_ovrf, w_rnd_udrf;

    always_comb begin
        w_prod     = r_acc[47:0];
        w_e0       = 10'(r_ex) + 10'(r_ey) - 10'(EXP_BIAS);
        w_mant     = w_prod[46:23];
        w_g        = w_prod[22];
        w_st       = |w_prod[21:0];
        w_e1       = w_e0;
        if (w_prod[47]) begin
            w_mant = w_prod[47:24];
            w_g    = w_prod[23];
            w_st   = |w_prod[22:0];
            w_e1   = w_e0 + 10'sd1;
        end
        w_inc    = round_inc(r_rmode, r_sign, w_mant[0], w_g, w_st);
        w_mant_r = {1'b0, w_mant} + {24'd0, w_inc};
        // A rounding carry out of 0xFFFFFF renormalises to 1.0 x 2^(e+1).
        if (w_mant_r[24]) begin
            w_mant_f = 24'h80_0000;
            w_e2     = w_e1 + 10'sd1;
        end else begin
            w_mant_f = w_mant_r[23:0];
            w_e2     = w_e1;
        end
        w_rnd_ovrf = 1'b0;
        w_rnd_udrf = 1'b0;
        if (w_e2 >= 10'sd255) begin
            w_rnd_ovrf = 1'b1;
            w_rnd_z    = ovf_result(r_rmode, r_sign);
        end else if (w_e2 <= 10'sd0) begin
            w_rnd_udrf = 1'b1;
            w_rnd_z    = {r_sign, 31'd0};
        end else begin
            w_rnd_z    = {r_sign, w_e2[7:0], w_mant_f[22:0]};
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_RND;
            S_RND:  w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mx    <= '0;
            r_my    <= '0;
            r_ex    <= '0;
            r_ey    <= '0;
            r_sign  <= 1'b0;
            r_rmode <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_z     <= '0;
            r_ovrf  <= 1'b0;
            r_udrf  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mx    <= {1'b1, fp_X[22:0]};
                r_my    <= {1'b1, fp_Y[22:0]};
                r_ex    <= fp_X[30:23];
                r_ey    <= fp_Y[30:23];
                r_sign  <= w_sign_in;
                r_rmode <= r_mode;
                r_cnt   <= '0;
                r_acc   <= '0;
                if (w_special) begin
                    r_z    <= w_spec_z;
                    r_ovrf <= 1'b0;
                    r_udrf <= 1'b0;
                end
            end
            if (r_state == S_CALC) begin
                r_acc <= r_acc + w_pp;
                if (!w_last) r_cnt <= r_cnt + 4'd1;
            end
            if (r_state == S_RND) begin
                r_z    <= w_rnd_z;
                r_ovrf <= w_rnd_ovrf;
                r_udrf <= w_rnd_udrf;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign fp_Z      = r_z;
    assign ovrf      = r_ovrf;
    assign udrf      = r_udrf;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_seq_ctrl
// Self-checking bench for fp_mul_seq_ctrl: directed corner cases plus random
// operand pairs compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_mul_seq_ctrl;

`ifdef FP_MUL_DIGIT2_EN
    localparam int LAT_NORMAL = 9;
`else
    localparam int LAT_NORMAL = 15;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [2:0]  r_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] fp_Z;
    logic        ovrf;
    logic        udrf;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    fp_mul_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fp_X     (fp_X),
        .fp_Y     (fp_Y),
        .r_mode   (r_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fp_Z     (fp_Z),
        .ovrf     (ovrf),
        .udrf     (udrf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer product, then rounding by comparing the
    // discarded remainder against one half ulp. Returns {ovrf, udrf, z}.
    function automatic logic [33:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] md);
        logic            s, up;
        int              ex, ey, e, sh, m;
        longint unsigned p, mant, rem, half;
        logic            nx, ny, ix, iy, zx, zy;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return {2'b00, 32'h7FC00000};
        if (ix || iy) return {2'b00, s, 8'hFF, 23'd0};
        if (zx || zy) return {2'b00, s, 31'd0};
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        e = ex + ey - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        mant = p >> sh;
        rem  = p - (mant << sh);
        half = 64'd1 << (sh - 1);
        m = (md > 3'd4) ? 0 : int'(md);
        case (m)
            0:       up = (rem > half) || (rem == half && mant[0]);
            1:       up = 1'b0;
            2:       up = s && (rem != 0);
            3:       up = !s && (rem != 0);
            default: up = (rem >= half);
        endcase
        mant = mant + longint'(up);
        if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
        if (e >= 255) begin
            case (m)
                1:       return {2'b10, s, 31'h7F7FFFFF};
                2:       return {2'b10, s ? 32'hFF800000 : 32'h7F7FFFFF};
                3:       return {2'b10, s ? 32'hFF7FFFFF : 32'h7F800000};
                default: return {2'b10, s, 8'hFF, 23'd0};
            endcase
        end
        if (e <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, 8'(e), 23'(mant)};
    endfunction

    task automatic run_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [2:0] md, input logic [31:0] ez, input logic eo,
                             input logic eu, input int elat, input int stall);
        int          lat;
        logic [31:0] zc;
        @(negedge clk);
        chk_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        fp_X = x; fp_Y = y; r_mode = md; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            chk_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
            rst = 1'b1; #2; rst = 1'b0;
            return;
        end
        chk_eq({tag, "_lat"}, 32'(lat + 1), 32'(elat));
        chk_eq({tag, "_z"}, fp_Z, ez);
        chk_eq({tag, "_ovrf"}, 32'(ovrf), 32'(eo));
        chk_eq({tag, "_udrf"}, 32'(udrf), 32'(eu));
        zc = fp_Z;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk_eq({tag, "_hold_z"}, fp_Z, zc);
            chk_eq({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            chk_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_eq({tag, "_released"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_ref(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] md, input int stall);
        logic [33:0] r;
        logic        spec;
        r    = ref_mul(x, y, md);
        spec = (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
               (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
        run_check(tag, x, y, md, r[31:0], r[33], r[32], spec ? 1 : LAT_NORMAL, stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] x, y;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        fp_X = '0; fp_Y = '0; r_mode = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", 32'(in_ready), 32'd1);
        chk_eq("rst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_fp_Z", fp_Z, 32'd0);
        chk_eq("rst_ovrf", 32'(ovrf), 32'd0);
        chk_eq("rst_udrf", 32'(udrf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_check("one_x_one", 32'h3F800000, 32'h3F800000, 3'b000, 32'h3F800000, 0, 0, LAT_NORMAL, 0);
        run_check("1p5_x_m2", 32'h3FC00000, 32'hC0000000, 3'b000, 32'hC0400000, 0, 0, LAT_NORMAL, 0);
        run_check("ulp_rne", 32'h3F800001, 32'h3F800001, 3'b000, 32'h3F800002, 0, 0, LAT_NORMAL, 0);
        run_check("ulp_rup", 32'h3F800001, 32'h3F800001, 3'b011, 32'h3F800003, 0, 0, LAT_NORMAL, 0);
        run_check("ovf_rne", 32'h7F000000, 32'h7F000000, 3'b000, 32'h7F800000, 1, 0, LAT_NORMAL, 0);
        run_check("ovf_rtz", 32'h7F000000, 32'h7F000000, 3'b001, 32'h7F7FFFFF, 1, 0, LAT_NORMAL, 0);
        run_check("ovf_rdn_neg", 32'hFF000000, 32'h7F000000, 3'b010, 32'hFF800000, 1, 0, LAT_NORMAL, 0);
        run_check("ovf_rup_neg", 32'hFF000000, 32'h7F000000, 3'b011, 32'hFF7FFFFF, 1, 0, LAT_NORMAL, 0);
        run_check("sub_x_neg1", 32'h00000001, 32'hBF800000, 3'b000, 32'h80000000, 0, 0, 1, 0);
        run_check("inf_x_zero", 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 0, 0, 1, 0);
        run_check("inf_x_neg2", 32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 0, 0, 1, 0);
        run_check("nan_x_one", 32'h3F800000, 32'h7F800123, 3'b001, 32'h7FC00000, 0, 0, 1, 0);
        run_check("udf_rne", 32'h00800000, 32'h3F000000, 3'b000, 32'h00000000, 0, 1, LAT_NORMAL, 0);
        run_check("stall5", 32'h40400000, 32'h40400000, 3'b000, 32'h41100000, 0, 0, LAT_NORMAL, 5);

        // Reset during CALC drops the transaction
        @(negedge clk);
        fp_X = 32'h40000000; fp_Y = 32'h40000000; r_mode = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("calc_busy", 32'(busy), 32'd1);
        chk_eq("calc_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        chk_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        chk_eq("midrst_busy", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk_eq("midrst_no_result", 32'(out_valid), 32'd0);
        run_check("after_rst", 32'h3FC00000, 32'h40000000, 3'b000, 32'h40400000, 0, 0, LAT_NORMAL, 0);

        // Random operands against the reference model
        for (int t = 0; t < 150; t++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 7) != 0) x[30:23] = 8'($urandom_range(60, 194));
            if ($urandom_range(0, 7) != 0) y[30:23] = 8'($urandom_range(60, 194));
            run_ref("rnd", x, y, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
